move_checker: RTL

- Sequencing controller that validates one chess move against the 8x8 board register file before the game controller commits it.
- Reads source, destination and intermediate squares through a single shared board read port, one square at a time.
- Applies per-piece move geometry and path-blocking rules, then reports a legal flag and a reason code with a done pulse.
- Sits between cursor/press handling and the board write logic; the controller only commits moves that come back legal.

---
 rtl/move_checker_if.sv | 46 ++++
 rtl/move_checker.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/move_checker_if.sv
// ---------------------------------------------------------------------------
// move_checker_if
//
// Groups the signals between the move checker and the logic around it: the
// game controller (request and result) and the board register file (read
// port). The "master" side is that surrounding logic. It issues the
// request, supplies board data and consumes the result. The "slave" side is
// the checker itself.
//
// Signals:
//   start                single-cycle move request (sampled only when idle)
//   src_x/src_y          source square
//   dst_x/dst_y          destination square
//   turn                 side to move, 0 white / 1 black
//   rd_en, rd_x, rd_y    board read strobe and address
//   rd_data              board entry for the address strobed one cycle earlier
//                        [4] occupied, [3] colour, [2:0] piece type
//   busy, done           checker activity and one-cycle completion pulse
//   legal, reason        result, valid while done is high and held afterwards
// ---------------------------------------------------------------------------
interface move_checker_if;
    logic       start;
    logic [2:0] src_x;
    logic [2:0] src_y;
    logic [2:0] dst_x;
    logic [2:0] dst_y;
    logic       turn;
    logic       rd_en;
    logic [2:0] rd_x;
    logic [2:0] rd_y;
    logic [7:0] rd_data;
    logic       busy;
    logic       done;
    logic       legal;
    logic [2:0] reason;

    modport master (
        output start, src_x, src_y, dst_x, dst_y, turn, rd_data,
        input  rd_en, rd_x, rd_y, busy, done, legal, reason
    );

    modport slave (
        input  start, src_x, src_y, dst_x, dst_y, turn, rd_data,
        output rd_en, rd_x, rd_y, busy, done, legal, reason
    );
endinterface

// File: rtl/move_checker.sv
// ---------------------------------------------------------------------------
// move_checker
//
// Validates one chess move against the board register file before the game
// controller commits it. The checker reads the source square, then the
// destination square, classifies the move, and for sliding moves (rook,
// bishop, queen, pawn double step) walks the squares strictly between
// source and destination through the same single read port. It stops at
// the first occupied square.
//
// Ports:
//   clk    system clock
//   rstn   asynchronous active-low reset; aborts any check without a done
//   mc     move_checker_if.slave: request, board read port and result
//
// Parameters:
//   PAWN_DOUBLE_EN  1 allows the pawn two-step move from its home row
//   WHITE_HOME_ROW  home row of white pawns (white moves toward +y)
//   BLACK_HOME_ROW  home row of black pawns (black moves toward -y)
//
// Timing, with start accepted at edge 0: done is high in cycle 4 when there
// is no walk, and in cycle 4+2k when the walk ends at intermediate square k.
// ---------------------------------------------------------------------------
module move_checker #(
    parameter int PAWN_DOUBLE_EN = 1,
    parameter int WHITE_HOME_ROW = 1,
    parameter int BLACK_HOME_ROW = 6
) (
    input  logic           clk,
    input  logic           rstn,
    move_checker_if.slave  mc
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_SRC,
        S_RD_DST,
        S_CLASSIFY,
        S_WALK_REQ,
        S_WALK_CHK,
        S_REPORT
    } state_t;

    localparam logic [2:0] R_OK           = 3'd0;
    localparam logic [2:0] R_NO_OWN_PIECE = 3'd1;
    localparam logic [2:0] R_OWN_DST      = 3'd2;
    localparam logic [2:0] R_BAD_GEOM     = 3'd3;
    localparam logic [2:0] R_BLOCKED      = 3'd4;
    localparam logic [2:0] R_SAME_SQ      = 3'd5;

    localparam logic [2:0] T_PAWN   = 3'd0;
    localparam logic [2:0] T_ROOK   = 3'd1;
    localparam logic [2:0] T_KNIGHT = 3'd2;
    localparam logic [2:0] T_BISHOP = 3'd3;
    localparam logic [2:0] T_QUEEN  = 3'd4;
    localparam logic [2:0] T_KING   = 3'd5;

    localparam logic [2:0] W_HOME = WHITE_HOME_ROW[2:0];
    localparam logic [2:0] B_HOME = BLACK_HOME_ROW[2:0];

    state_t     state_reg;
    logic       busy_reg;
    logic       done_reg;
    logic       legal_reg;
    logic [2:0] reason_reg;
    logic       rd_en_reg;
    logic [2:0] rd_x_reg;
    logic [2:0] rd_y_reg;

    // Operands latched at start
    logic [2:0] src_x_reg;
    logic [2:0] src_y_reg;
    logic [2:0] dst_x_reg;
    logic [2:0] dst_y_reg;
    logic       turn_reg;

    // Source piece without the don't-care upper bits
    logic [4:0] src_piece_reg;

    // Walk state. The current intermediate square is always the last read
    // address, so rd_x_reg/rd_y_reg double as the walk position.
    logic [2:0] step_x_reg;
    logic [2:0] step_y_reg;
    logic [3:0] walk_cnt_reg;

    // Upper board bits carry no meaning for the checker
    logic unused_rd_bits;
    assign unused_rd_bits = &{1'b0, mc.rd_data[7:5]};

    // ------------------------------------------------------------------
    // Move classification. Only meaningful in CLASSIFY, where rd_data
    // holds the destination square.
    // ------------------------------------------------------------------
    logic [3:0] dx;
    logic [3:0] dy;
    logic [3:0] adx;
    logic [3:0] ady;
    logic [3:0] max_d;
    logic [3:0] fwd;
    logic [3:0] fwd2;
    logic [2:0] home_row;
    logic [2:0] step_x;
    logic [2:0] step_y;
    logic       dst_occ;
    logic       dst_col;
    logic       geo_ok;
    logic       path_req;
    logic [2:0] cls_reason;
    logic [3:0] walk_len;

    always_comb begin
        // Signed 4-bit differences; an unsigned 3-bit step of 7 is -1 mod 8
        dx       = {1'b0, dst_x_reg} - {1'b0, src_x_reg};
        dy       = {1'b0, dst_y_reg} - {1'b0, src_y_reg};
        adx      = dx[3] ? (4'd0 - dx) : dx;
        ady      = dy[3] ? (4'd0 - dy) : dy;
        max_d    = (adx > ady) ? adx : ady;
        step_x   = dx[3] ? 3'd7 : ((dx == 4'd0) ? 3'd0 : 3'd1);
        step_y   = dy[3] ? 3'd7 : ((dy == 4'd0) ? 3'd0 : 3'd1);
        fwd      = turn_reg ? 4'hF : 4'h1;
        fwd2     = turn_reg ? 4'hE : 4'h2;
        home_row = turn_reg ? B_HOME : W_HOME;
        dst_occ  = mc.rd_data[4];
        dst_col  = mc.rd_data[3];

        geo_ok   = 1'b0;
        path_req = 1'b0;
        case (src_piece_reg[2:0])
            T_PAWN: begin
                if (dx == 4'd0 && dy == fwd && !dst_occ) begin
                    geo_ok = 1'b1;
                end else if (PAWN_DOUBLE_EN != 0 && dx == 4'd0 && dy == fwd2 &&
                             src_y_reg == home_row && !dst_occ) begin
                    geo_ok   = 1'b1;
                    path_req = 1'b1;
                end else if (adx == 4'd1 && dy == fwd && dst_occ) begin
                    // Own-colour destinations are rejected before geometry,
                    // so an occupied destination here is an opponent piece.
                    geo_ok = 1'b1;
                end
            end
            T_ROOK: begin
                geo_ok   = (dx == 4'd0) != (dy == 4'd0);
                path_req = 1'b1;
            end
            T_KNIGHT: begin
                geo_ok = (adx == 4'd1 && ady == 4'd2) || (adx == 4'd2 && ady == 4'd1);
            end
            T_BISHOP: begin
                geo_ok   = (adx == ady);
                path_req = 1'b1;
            end
            T_QUEEN: begin
                geo_ok   = ((dx == 4'd0) != (dy == 4'd0)) || (adx == ady);
                path_req = 1'b1;
            end
            T_KING: begin
                geo_ok = (adx <= 4'd1) && (ady <= 4'd1);
            end
            default: begin
                geo_ok = 1'b0;
            end
        endcase

        // Squares strictly between src and dst along a straight line
        walk_len = path_req ? (max_d - 4'd1) : 4'd0;

        if (dx == 4'd0 && dy == 4'd0) begin
            cls_reason = R_SAME_SQ;
        end else if (!src_piece_reg[4] || src_piece_reg[3] != turn_reg) begin
            cls_reason = R_NO_OWN_PIECE;
        end else if (dst_occ && dst_col == turn_reg) begin
            cls_reason = R_OWN_DST;
        end else if (!geo_ok) begin
            cls_reason = R_BAD_GEOM;
        end else begin
            cls_reason = R_OK;
        end
    end

    // ------------------------------------------------------------------
    // Sequencer with registered outputs. rd_en and done default low each
    // cycle and are raised on the transition into the state that owns them.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg     <= S_IDLE;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            legal_reg     <= 1'b0;
            reason_reg    <= R_OK;
            rd_en_reg     <= 1'b0;
            rd_x_reg      <= 3'd0;
            rd_y_reg      <= 3'd0;
            src_x_reg     <= 3'd0;
            src_y_reg     <= 3'd0;
            dst_x_reg     <= 3'd0;
            dst_y_reg     <= 3'd0;
            turn_reg      <= 1'b0;
            src_piece_reg <= 5'd0;
            step_x_reg    <= 3'd0;
            step_y_reg    <= 3'd0;
            walk_cnt_reg  <= 4'd0;
        end else begin
            done_reg  <= 1'b0;
            rd_en_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (mc.start) begin
                        src_x_reg <= mc.src_x;
                        src_y_reg <= mc.src_y;
                        dst_x_reg <= mc.dst_x;
                        dst_y_reg <= mc.dst_y;
                        turn_reg  <= mc.turn;
                        busy_reg  <= 1'b1;
                        rd_en_reg <= 1'b1;
                        rd_x_reg  <= mc.src_x;
                        rd_y_reg  <= mc.src_y;
                        state_reg <= S_RD_SRC;
                    end
                end
                S_RD_SRC: begin
                    rd_en_reg <= 1'b1;
                    rd_x_reg  <= dst_x_reg;
                    rd_y_reg  <= dst_y_reg;
                    state_reg <= S_RD_DST;
                end
                S_RD_DST: begin
                    src_piece_reg <= mc.rd_data[4:0];
                    state_reg     <= S_CLASSIFY;
                end
                S_CLASSIFY: begin
                    if (cls_reason != R_OK || walk_len == 4'd0) begin
                        done_reg   <= 1'b1;
                        legal_reg  <= (cls_reason == R_OK);
                        reason_reg <= cls_reason;
                        state_reg  <= S_REPORT;
                    end else begin
                        step_x_reg   <= step_x;
                        step_y_reg   <= step_y;
                        walk_cnt_reg <= walk_len;
                        rd_en_reg    <= 1'b1;
                        rd_x_reg     <= src_x_reg + step_x;
                        rd_y_reg     <= src_y_reg + step_y;
                        state_reg    <= S_WALK_REQ;
                    end
                end
                S_WALK_REQ: begin
                    state_reg <= S_WALK_CHK;
                end
                S_WALK_CHK: begin
                    if (mc.rd_data[4]) begin
                        done_reg   <= 1'b1;
                        legal_reg  <= 1'b0;
                        reason_reg <= R_BLOCKED;
                        state_reg  <= S_REPORT;
                    end else if (walk_cnt_reg == 4'd1) begin
                        done_reg   <= 1'b1;
                        legal_reg  <= 1'b1;
                        reason_reg <= R_OK;
                        state_reg  <= S_REPORT;
                    end else begin
                        walk_cnt_reg <= walk_cnt_reg - 4'd1;
                        rd_en_reg    <= 1'b1;
                        rd_x_reg     <= rd_x_reg + step_x_reg;
                        rd_y_reg     <= rd_y_reg + step_y_reg;
                        state_reg    <= S_WALK_REQ;
                    end
                end
                S_REPORT: begin
                    // A start coinciding with this cycle is deliberately dropped
                    busy_reg  <= 1'b0;
                    state_reg <= S_IDLE;
                end
                default: begin
                    busy_reg  <= 1'b0;
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign mc.rd_en  = rd_en_reg;
    assign mc.rd_x   = rd_x_reg;
    assign mc.rd_y   = rd_y_reg;
    assign mc.busy   = busy_reg;
    assign mc.done   = done_reg;
    assign mc.legal  = legal_reg;
    assign mc.reason = reason_reg;

endmodule
